// File: rtl/snax_cgra_csr_pkg.sv
// Shared types and address/bit constants for the CGRA-side CSR manager.
package snax_cgra_csr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Control CSRs sit directly above the configuration bank.
   localparam int unsigned CSR_START_OFS  = 0;
   localparam int unsigned CSR_STATUS_OFS = 1;
   localparam int unsigned CSR_CYCLES_OFS = 2;

   localparam int unsigned STATUS_BUSY_BIT = 0;
   localparam int unsigned STATUS_DONE_BIT = 1;

endpackage

// File: rtl/snax_cgra_csr_manager_if.sv
// Simplified CSR request/response channel between the SNAX bridge and the CGRA CSR manager.
interface snax_cgra_csr_manager_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64
);
   logic [DataWidth-1:0] req_data;
   logic [AddrWidth-1:0] req_addr;
   logic                 req_write;
   logic                 req_valid;
   logic                 req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DataWidth-1:0] rsp_data;

   modport master (
      output req_data, req_addr, req_write, req_valid, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_data, req_addr, req_write, req_valid, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/snax_cgra_csr_rsp_reg.sv
// Single-entry response slot: captures one response and holds it until the consumer takes it.
module snax_cgra_csr_rsp_reg #(
   parameter int unsigned DataWidth = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] push_data_i,
   output logic                 ready_o,
   output logic                 valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] data_o
);
   logic                 valid_q;
   logic [DataWidth-1:0] data_q;

   // Ready only when empty, so a slot freed this cycle accepts again next cycle.
   assign ready_o = !valid_q;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (push_i) begin
         valid_q <= 1'b1;
         data_q  <= push_data_i;
      end else if (valid_q && rsp_ready_i) begin
         valid_q <= 1'b0;
      end
   end
endmodule

// File: rtl/snax_cgra_csr_manager.sv
// CGRA CSR manager: config bank, launch/status/cycle CSRs and the start/busy handshake.
//   state | meaning
//   IDLE  | CGRA idle; CFG writable, START write with bit0=1 launches
//   BUSY  | CGRA running; CFG/START writes dropped, cycle counter running
module snax_cgra_csr_manager
   import snax_cgra_csr_pkg::*;
#(
   parameter int unsigned NumCfgCsr = 8,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   snax_cgra_csr_manager_if.slave         csr,
   output logic [NumCfgCsr*DataWidth-1:0] cfg_o,
   output logic                           cgra_start_o,
   input  logic                           cgra_done_i,
   output logic                           cgra_busy_o
);
   localparam logic [AddrWidth-1:0] AddrStart  = AddrWidth'(NumCfgCsr + CSR_START_OFS);
   localparam logic [AddrWidth-1:0] AddrStatus = AddrWidth'(NumCfgCsr + CSR_STATUS_OFS);
   localparam logic [AddrWidth-1:0] AddrCycles = AddrWidth'(NumCfgCsr + CSR_CYCLES_OFS);

   state_e               state_q, state_d;
   logic [DataWidth-1:0] cfg_q [NumCfgCsr];
   logic [DataWidth-1:0] cycles_q;
   logic                 done_sticky_q;
   logic                 start_q;
   logic                 accept;
   logic                 wr_acc;
   logic                 launch;
   logic [DataWidth-1:0] rd_data;

   assign accept = csr.req_valid && csr.req_ready;
   assign wr_acc = accept && csr.req_write;
   assign launch = wr_acc && (csr.req_addr == AddrStart) && csr.req_data[0] && (state_q == IDLE);

   assign cgra_start_o = start_q;
   assign cgra_busy_o  = (state_q == BUSY);

   for (genvar g = 0; g < NumCfgCsr; g++) begin : g_cfg_out
      assign cfg_o[g*DataWidth +: DataWidth] = cfg_q[g];
   end

   // Read data reflects register state before this cycle's updates.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NumCfgCsr; k++) begin
         if (csr.req_addr == AddrWidth'(k)) rd_data = cfg_q[k];
      end
      if (csr.req_addr == AddrStatus) begin
         rd_data[STATUS_BUSY_BIT] = (state_q == BUSY);
         rd_data[STATUS_DONE_BIT] = done_sticky_q;
      end
      if (csr.req_addr == AddrCycles) rd_data = cycles_q;
      if (csr.req_write) rd_data = '0;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (launch) state_d = BUSY;
         BUSY: if (cgra_done_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         start_q       <= 1'b0;
         done_sticky_q <= 1'b0;
         cycles_q      <= '0;
      end else begin
         state_q <= state_d;
         start_q <= launch;
         if (launch) begin
            done_sticky_q <= 1'b0;
            cycles_q      <= '0;
         end else if (state_q == BUSY) begin
            if (cgra_done_i) done_sticky_q <= 1'b1;
            if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NumCfgCsr; k++) cfg_q[k] <= '0;
      end else begin
         for (int k = 0; k < NumCfgCsr; k++) begin
            if (wr_acc && (state_q == IDLE) && (csr.req_addr == AddrWidth'(k)))
               cfg_q[k] <= csr.req_data;
         end
      end
   end

   snax_cgra_csr_rsp_reg #(
      .DataWidth (DataWidth)
   ) i_rsp_reg (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (accept),
      .push_data_i (rd_data),
      .ready_o     (csr.req_ready),
      .valid_o     (csr.rsp_valid),
      .rsp_ready_i (csr.rsp_ready),
      .data_o      (csr.rsp_data)
   );
endmodule

// File: tb/tb_snax_cgra_csr_manager.sv
// Directed bench for the CGRA CSR manager: vector tables plus hand-written handshake/FSM sequences.
module tb_snax_cgra_csr_manager;
   localparam int N = 8;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic [N*64-1:0]  cfg_o;
   logic             cgra_start_o;
   logic             cgra_done_i;
   logic             cgra_busy_o;

   always #5 clk_i = ~clk_i;

   snax_cgra_csr_manager_if #(.AddrWidth(32), .DataWidth(64)) csr ();

   snax_cgra_csr_manager #(.NumCfgCsr(N), .AddrWidth(32), .DataWidth(64)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .csr          (csr),
      .cfg_o        (cfg_o),
      .cgra_start_o (cgra_start_o),
      .cgra_done_i  (cgra_done_i),
      .cgra_busy_o  (cgra_busy_o)
   );

   typedef struct {
      string       name;
      logic        wr;
      logic [31:0] addr;
      logic [63:0] data;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [24];
   int   tests = 0;
   int   fails = 0;
   int   start_cnt = 0;

   always @(negedge clk_i) if (cgra_start_o) start_cnt++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic txn(input logic w, input logic [31:0] a, input logic [63:0] d,
                      output logic [63:0] r);
      int n;
      @(negedge clk_i);
      csr.req_write = w; csr.req_addr = a; csr.req_data = d;
      csr.req_valid = 1'b1; csr.rsp_ready = 1'b1;
      n = 0;
      while (!csr.req_ready && n < 20) begin @(negedge clk_i); n++; end
      if (n >= 20) begin
         tests++; fails++;
         $display("FAIL req_ready_timeout addr=%0d", a);
      end
      @(posedge clk_i); #1;
      csr.req_valid = 1'b0;
      check("rsp_latency", {63'd0, csr.rsp_valid}, 64'd1);
      r = csr.rsp_data;
      @(posedge clk_i); #1;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      logic [63:0] r;
      for (int i = lo; i <= hi; i++) begin
         txn(vecs[i].wr, vecs[i].addr, vecs[i].data, r);
         check(vecs[i].name, r, vecs[i].exp);
      end
   endtask

   initial begin
      logic [63:0] r;
      int          s0;

      vecs[0]  = '{"status_after_reset", 1'b0, 32'd9,  64'd0, 64'd0};
      vecs[1]  = '{"wr_cfg3",      1'b1, 32'd3,  64'hDEAD_BEEF_0123_4567, 64'd0};
      vecs[2]  = '{"rd_cfg3",      1'b0, 32'd3,  64'd0, 64'hDEAD_BEEF_0123_4567};
      vecs[3]  = '{"wr_cfg0",      1'b1, 32'd0,  64'h5A, 64'd0};
      vecs[4]  = '{"rd_cfg0",      1'b0, 32'd0,  64'd0, 64'h5A};
      vecs[5]  = '{"wr_cfg7",      1'b1, 32'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
      vecs[6]  = '{"rd_cfg7",      1'b0, 32'd7,  64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[7]  = '{"rd_start",     1'b0, 32'd8,  64'd0, 64'd0};
      vecs[8]  = '{"rd_cycles0",   1'b0, 32'd10, 64'd0, 64'd0};
      vecs[9]  = '{"wr_unmapped",  1'b1, 32'd15, 64'h1234, 64'd0};
      vecs[10] = '{"rd_unmapped",  1'b0, 32'd15, 64'd0, 64'd0};
      vecs[11] = '{"wr_status_ro", 1'b1, 32'd9,  64'hFF, 64'd0};
      vecs[12] = '{"rd_status_ro", 1'b0, 32'd9,  64'd0, 64'd0};
      vecs[13] = '{"wr_start_b0z", 1'b1, 32'd8,  64'h2, 64'd0};
      vecs[14] = '{"rd_status_nolaunch", 1'b0, 32'd9, 64'd0, 64'd0};
      vecs[15] = '{"rd_status_busy",  1'b0, 32'd9, 64'd0, 64'd1};
      vecs[16] = '{"wr_cfg0_busy",    1'b1, 32'd0, 64'd5, 64'd0};
      vecs[17] = '{"rd_cfg0_busy",    1'b0, 32'd0, 64'd0, 64'h5A};
      vecs[18] = '{"wr_start_busy",   1'b1, 32'd8, 64'd1, 64'd0};
      vecs[19] = '{"rd_status_busy2", 1'b0, 32'd9, 64'd0, 64'd1};
      vecs[20] = '{"rd_cfg3_postrst",   1'b0, 32'd3,  64'd0, 64'd0};
      vecs[21] = '{"rd_cycles_postrst", 1'b0, 32'd10, 64'd0, 64'd0};
      vecs[22] = '{"rd_status_postrst", 1'b0, 32'd9,  64'd0, 64'd0};
      vecs[23] = '{"rd_cfg7_postrst",   1'b0, 32'd7,  64'd0, 64'd0};

      csr.req_write = 1'b0; csr.req_addr = '0; csr.req_data = '0;
      csr.req_valid = 1'b0; csr.rsp_ready = 1'b1; cgra_done_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("rst_req_ready", {63'd0, csr.req_ready}, 64'd1);
      check("rst_rsp_valid", {63'd0, csr.rsp_valid}, 64'd0);
      check("rst_start",     {63'd0, cgra_start_o}, 64'd0);
      check("rst_busy",      {63'd0, cgra_busy_o}, 64'd0);
      check("rst_cfg_o_lo",  cfg_o[63:0], 64'd0);

      run_vecs(0, 14);
      check("cfg_o_cfg3", cfg_o[255:192], 64'hDEAD_BEEF_0123_4567);
      check("cfg_o_cfg0", cfg_o[63:0], 64'h5A);

      // cfg_o updates exactly one cycle after acceptance
      @(negedge clk_i);
      csr.req_write = 1'b1; csr.req_addr = 32'd1; csr.req_data = 64'h1111_2222_3333_4444;
      csr.req_valid = 1'b1;
      check("cfg1_before_accept", cfg_o[127:64], 64'd0);
      @(posedge clk_i); #1;
      csr.req_valid = 1'b0;
      check("cfg1_after_accept", cfg_o[127:64], 64'h1111_2222_3333_4444);
      @(posedge clk_i); #1;

      // launch, 10 quiet busy cycles, done in the 11th
      s0 = start_cnt;
      @(negedge clk_i);
      csr.req_write = 1'b1; csr.req_addr = 32'd8; csr.req_data = 64'd1; csr.req_valid = 1'b1;
      @(posedge clk_i); #1;
      csr.req_valid = 1'b0;
      check("launch_start", {63'd0, cgra_start_o}, 64'd1);
      check("launch_busy",  {63'd0, cgra_busy_o}, 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         if (i == 0) check("start_pulse_end", {63'd0, cgra_start_o}, 64'd0);
      end
      check("busy_before_done", {63'd0, cgra_busy_o}, 64'd1);
      cgra_done_i = 1'b1;
      @(posedge clk_i); #1;
      cgra_done_i = 1'b0;
      check("busy_after_done", {63'd0, cgra_busy_o}, 64'd0);
      check("start_pulses_run1", 64'(start_cnt - s0), 64'd1);
      txn(1'b0, 32'd10, 64'd0, r); check("cycles_run1", r, 64'd11);
      txn(1'b0, 32'd9,  64'd0, r); check("status_run1", r, 64'd2);

      // done while idle is ignored; counter holds
      @(negedge clk_i); cgra_done_i = 1'b1;
      @(negedge clk_i); cgra_done_i = 1'b0;
      check("busy_idle_done", {63'd0, cgra_busy_o}, 64'd0);
      txn(1'b0, 32'd10, 64'd0, r); check("cycles_hold", r, 64'd11);

      // second run: writes while busy are acknowledged but dropped
      s0 = start_cnt;
      txn(1'b1, 32'd8, 64'd1, r); check("wr_start2", r, 64'd0);
      run_vecs(15, 19);
      check("start_pulses_run2", 64'(start_cnt - s0), 64'd1);
      check("cfg_o_cfg0_busy", cfg_o[63:0], 64'h5A);

      // STATUS read in the done cycle returns the pre-update value
      @(negedge clk_i);
      csr.req_write = 1'b0; csr.req_addr = 32'd9; csr.req_valid = 1'b1; cgra_done_i = 1'b1;
      @(posedge clk_i); #1;
      csr.req_valid = 1'b0; cgra_done_i = 1'b0;
      check("status_done_cycle", csr.rsp_data, 64'd1);
      check("busy_run2_end", {63'd0, cgra_busy_o}, 64'd0);
      @(posedge clk_i); #1;
      txn(1'b0, 32'd9, 64'd0, r); check("status_run2", r, 64'd2);

      // response backpressure
      @(negedge clk_i);
      csr.req_write = 1'b0; csr.req_addr = 32'd3; csr.req_valid = 1'b1; csr.rsp_ready = 1'b0;
      @(posedge clk_i); #1;
      csr.req_addr = 32'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("stall_rsp_valid", {63'd0, csr.rsp_valid}, 64'd1);
         check("stall_rsp_data",  csr.rsp_data, 64'hDEAD_BEEF_0123_4567);
         check("stall_req_ready", {63'd0, csr.req_ready}, 64'd0);
      end
      csr.rsp_ready = 1'b1;
      @(posedge clk_i); #1;
      check("release_rsp_valid", {63'd0, csr.rsp_valid}, 64'd0);
      check("release_req_ready", {63'd0, csr.req_ready}, 64'd1);
      @(posedge clk_i); #1;
      csr.req_valid = 1'b0;
      check("next_rsp_valid", {63'd0, csr.rsp_valid}, 64'd1);
      check("next_rsp_data",  csr.rsp_data, 64'h5A);
      @(posedge clk_i); #1;

      // reset in the middle of a run with a response parked in the slot
      txn(1'b1, 32'd8, 64'd1, r);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      csr.req_write = 1'b0; csr.req_addr = 32'd3; csr.req_valid = 1'b1; csr.rsp_ready = 1'b0;
      @(posedge clk_i); #1;
      csr.req_valid = 1'b0;
      check("pre_rst_rsp_valid", {63'd0, csr.rsp_valid}, 64'd1);
      check("pre_rst_busy", {63'd0, cgra_busy_o}, 64'd1);
      #2 rst_ni = 1'b0;
      #1;
      check("midrst_busy",      {63'd0, cgra_busy_o}, 64'd0);
      check("midrst_rsp_valid", {63'd0, csr.rsp_valid}, 64'd0);
      check("midrst_cfg_o_3",   cfg_o[255:192], 64'd0);
      check("midrst_cfg_o_0",   cfg_o[63:0], 64'd0);
      csr.rsp_ready = 1'b1;
      s0 = start_cnt;
      @(negedge clk_i); rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      check("postrst_no_start", 64'(start_cnt - s0), 64'd0);
      check("postrst_busy", {63'd0, cgra_busy_o}, 64'd0);
      run_vecs(20, 23);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end
endmodule
